health_ctrl: RTL and testbench

//  Per-fighter hit-point controller. Takes damage/heal requests from a player or NPC, arbitrates them and tracks HP.

---
 rtl/health_ctrl.sv | 119 +++++++++++
 tb/tb_health_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/health_ctrl.sv
// health_ctrl: per-fighter HP controller with hit arbitration, invulnerability window and KO.
// Optional regen timer enabled by defining HEALTH_REGEN_EN.
module health_ctrl #(
  parameter int MAX_HP        = 5,
  parameter int PROJ_DMG      = 2,
  parameter int MELEE_DMG     = 1,
  parameter int INVULN_FRAMES = 30,
  parameter int REGEN_FRAMES  = 120
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       round_start,
  input  logic       proj_req,
  output logic       proj_ack,
  input  logic       melee_req,
  output logic       melee_ack,
  input  logic       heal_req,
  output logic       heal_ack,
  output logic [2:0] hp,
  output logic [4:0] health_en,
  output logic       invuln,
  output logic       ko
);
  typedef enum logic [1:0] {ALIVE, INVULN, KO} state_t;
  localparam logic [2:0] LP_MAX   = 3'(MAX_HP);
  localparam logic [2:0] LP_PROJ  = 3'(PROJ_DMG);
  localparam logic [2:0] LP_MELEE = 3'(MELEE_DMG);
  localparam logic [5:0] LP_INV   = 6'(INVULN_FRAMES);
  if (MAX_HP != 5 || PROJ_DMG < 1 || MELEE_DMG < 1 || INVULN_FRAMES < 1 || INVULN_FRAMES > 63 ||
      REGEN_FRAMES < 1 || REGEN_FRAMES > 127) begin : g_bad_param
    $error("health_ctrl: parameter out of range");
  end
  state_t     r_state, w_state_n;
  logic [2:0] r_hp, w_hp_n, r_ack, w_ack_n, w_pend, w_gnt, w_dmg;
  logic [4:0] r_en, w_en_n;
  logic [5:0] r_timer, w_timer_n;
  logic       r_frame_q, w_tick, w_hit;
`ifdef HEALTH_REGEN_EN
  localparam logic [6:0] LP_REGEN = 7'(REGEN_FRAMES);
  logic [6:0] r_regen, w_regen_n;
`endif
  assign w_tick = frame_clk & ~r_frame_q;
  // a source that was acked last cycle still shows req; masking it keeps acks single-cycle
  assign w_pend = {proj_req & ~r_ack[2], melee_req & ~r_ack[1], heal_req & ~r_ack[0]};
  assign w_gnt  = w_pend[2] ? 3'b100 : w_pend[1] ? 3'b010 : w_pend[0] ? 3'b001 : 3'b000;
  assign w_dmg  = w_gnt[2] ? LP_PROJ : LP_MELEE;
  assign w_hit  = (r_state == ALIVE) & (w_gnt[2] | w_gnt[1]);
  for (genvar i = 0; i < 5; i++) assign w_en_n[i] = w_hp_n > 3'(i);
  always_comb begin
    w_state_n = r_state;
    w_hp_n    = r_hp;
    w_timer_n = r_timer;
    w_ack_n   = round_start ? 3'b000 : w_gnt;
`ifdef HEALTH_REGEN_EN
    w_regen_n = '0;
`endif
    if (round_start) begin
      w_state_n = ALIVE;
      w_hp_n    = LP_MAX;
      w_timer_n = '0;
    end else if (r_state != KO) begin
      if (w_hit) begin
        w_hp_n    = (r_hp > w_dmg) ? r_hp - w_dmg : 3'd0;
        w_state_n = (w_hp_n == 3'd0) ? KO : INVULN;
        w_timer_n = '0;
      end else if (w_gnt[0]) begin
        w_hp_n = (r_hp < LP_MAX) ? r_hp + 3'd1 : LP_MAX;
      end
      if (r_state == INVULN && w_tick) begin
        w_timer_n = r_timer + 6'd1;
        if (w_timer_n == LP_INV) begin
          w_state_n = ALIVE;
          w_timer_n = '0;
        end
      end
`ifdef HEALTH_REGEN_EN
      // a regen step coinciding with a heal still yields a single +1
      if (r_state == ALIVE && !w_hit && r_hp < LP_MAX) begin
        w_regen_n = r_regen + {6'd0, w_tick};
        if (w_regen_n == LP_REGEN) begin
          w_hp_n    = r_hp + 3'd1;
          w_regen_n = '0;
        end
      end
`endif
    end
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= ALIVE;
      r_hp      <= LP_MAX;
      r_en      <= 5'b11111;
      r_ack     <= '0;
      r_timer   <= '0;
      r_frame_q <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_hp      <= w_hp_n;
      r_en      <= w_en_n;
      r_ack     <= w_ack_n;
      r_timer   <= w_timer_n;
      r_frame_q <= frame_clk;
    end
  end
`ifdef HEALTH_REGEN_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_regen <= '0;
    else r_regen <= w_regen_n;
  end
`endif
  assign proj_ack  = r_ack[2];
  assign melee_ack = r_ack[1];
  assign heal_ack  = r_ack[0];
  assign hp        = r_hp;
  assign health_en = r_en;
  assign invuln    = (r_state == INVULN);
  assign ko        = (r_state == KO);
endmodule

// File: tb/tb_health_ctrl.sv
// tb_health_ctrl: table-driven handshake vectors plus directed invuln, KO, regen and reset sequences.
module tb_health_ctrl;
  logic       Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0, round_start = 1'b0;
  logic       proj_req = 1'b0, melee_req = 1'b0, heal_req = 1'b0;
  logic       proj_ack, melee_ack, heal_ack, invuln, ko;
  logic [2:0] hp;
  logic [4:0] health_en;
  int         n_tests = 0, n_fail = 0;
`ifdef HEALTH_REGEN_EN
  localparam bit REGEN = 1'b1;
`else
  localparam bit REGEN = 1'b0;
`endif
  health_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .round_start(round_start),
    .proj_req(proj_req), .proj_ack(proj_ack), .melee_req(melee_req), .melee_ack(melee_ack),
    .heal_req(heal_req), .heal_ack(heal_ack), .hp(hp), .health_en(health_en),
    .invuln(invuln), .ko(ko)
  );
  always #5 Clk = ~Clk;
  typedef struct {
    logic       rs, p, m, h;
    logic [2:0] hp;
    logic [4:0] en;
    logic       inv, ko;
    logic [2:0] ack;
  } vec_t;
  vec_t v[15];
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc(input logic rs, p, m, h);
    round_start = rs; proj_req = p; melee_req = m; heal_req = h;
    @(negedge Clk);
    round_start = 1'b0; proj_req = 1'b0; melee_req = 1'b0; heal_req = 1'b0;
  endtask
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      frame_clk = 1'b1;
      @(negedge Clk);
      frame_clk = 1'b0;
      @(negedge Clk);
    end
  endtask
  function automatic logic [15:0] st();
    return {3'b0, hp, health_en, invuln, ko, proj_ack, melee_ack, heal_ack};
  endfunction
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    v[0]  = '{0,0,0,0, 3'd5, 5'b11111, 0, 0, 3'b000};
    v[1]  = '{0,1,0,0, 3'd3, 5'b00111, 1, 0, 3'b100};
    v[2]  = '{0,0,0,0, 3'd3, 5'b00111, 1, 0, 3'b000};
    v[3]  = '{0,0,1,1, 3'd3, 5'b00111, 1, 0, 3'b010};
    v[4]  = '{0,0,0,1, 3'd4, 5'b01111, 1, 0, 3'b001};
    v[5]  = '{0,0,0,0, 3'd4, 5'b01111, 1, 0, 3'b000};
    v[6]  = '{1,1,0,0, 3'd5, 5'b11111, 0, 0, 3'b000};
    v[7]  = '{0,1,0,0, 3'd3, 5'b00111, 1, 0, 3'b100};
    v[8]  = '{1,0,0,0, 3'd5, 5'b11111, 0, 0, 3'b000};
    v[9]  = '{0,0,1,0, 3'd4, 5'b01111, 1, 0, 3'b010};
    v[10] = '{1,0,0,0, 3'd5, 5'b11111, 0, 0, 3'b000};
    v[11] = '{0,0,0,1, 3'd5, 5'b11111, 0, 0, 3'b001};
    v[12] = '{0,1,1,0, 3'd3, 5'b00111, 1, 0, 3'b100};
    v[13] = '{0,0,1,0, 3'd3, 5'b00111, 1, 0, 3'b010};
    v[14] = '{1,0,0,0, 3'd5, 5'b11111, 0, 0, 3'b000};
    repeat (3) @(negedge Clk);
    chk("reset_state", st(), {3'b0, 3'd5, 5'b11111, 2'b00, 3'b000});
    Reset_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      cyc(v[i].rs, v[i].p, v[i].m, v[i].h);
      chk($sformatf("vec%0d", i), st(), {3'b0, v[i].hp, v[i].en, v[i].inv, v[i].ko, v[i].ack});
    end
    cyc(0,1,0,0);
    ticks(29);
    chk("invuln_29", {15'b0, invuln}, 16'd1);
    ticks(1);
    chk("invuln_30", {15'b0, invuln}, 16'd0);
    chk("hp_after_window", {13'b0, hp}, 16'd3);
    cyc(1,0,0,0);
    cyc(0,1,0,0);
    ticks(30);
    cyc(0,1,0,0);
    chk("hp_1", st(), {3'b0, 3'd1, 5'b00001, 2'b10, 3'b100});
    ticks(30);
    cyc(0,1,0,0);
    chk("ko_sat", st(), {3'b0, 3'd0, 5'b00000, 2'b01, 3'b100});
    cyc(0,0,0,1);
    chk("ko_heal", st(), {3'b0, 3'd0, 5'b00000, 2'b01, 3'b001});
    cyc(0,0,0,0);
    cyc(1,0,0,0);
    chk("ko_round", st(), {3'b0, 3'd5, 5'b11111, 2'b00, 3'b000});
    cyc(0,0,1,0);
    ticks(30);
    chk("regen_start", st(), {3'b0, 3'd4, 5'b01111, 2'b00, 3'b000});
    ticks(119);
    chk("regen_119", {13'b0, hp}, 16'd4);
    ticks(1);
    chk("regen_120", {13'b0, hp}, REGEN ? 16'd5 : 16'd4);
    cyc(1,0,0,0);
    cyc(0,0,1,0);
    ticks(130);
    cyc(0,0,1,0);
    chk("regen_hit", st(), {3'b0, 3'd3, 5'b00111, 2'b10, 3'b010});
    ticks(30);
    ticks(119);
    chk("regen_restart_119", {13'b0, hp}, 16'd3);
    ticks(1);
    chk("regen_restart_120", {13'b0, hp}, REGEN ? 16'd4 : 16'd3);
    cyc(1,0,0,0);
    cyc(0,1,0,0);
    ticks(5);
    proj_req = 1'b1;
    #2 Reset_n = 1'b0;
    #1 chk("async_reset", st(), {3'b0, 3'd5, 5'b11111, 2'b00, 3'b000});
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    proj_req = 1'b0;
    chk("reserve_after_reset", st(), {3'b0, 3'd3, 5'b00111, 2'b10, 3'b100});
    @(negedge Clk);
    chk("ack_single", {15'b0, proj_ack}, 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
